// File: rtl/round_key_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : round_key_fetch
//  Purpose  : Streams expanded AES-128 round keys out of the round-key RAM
//             read port into the cipher datapath over a valid/ready handshake,
//             absorbing the RAM's one-cycle registered read latency.
//  Config   : KEY_FETCH_REVERSE_EN - when defined, 'reverse' selects
//             descending (decrypt) key order; otherwise order is ascending.
//  Revision : 1.0 - initial release
// ============================================================================
module round_key_fetch #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_KEYS      = 11,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     reverse,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0]    doutb,
    output logic [DATA_WIDTH-1:0]    key_out,
    output logic [ADDRESS_WIDTH-1:0] key_idx,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic                     key_last,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NUM_KEYS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE     = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] ONE      = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   done_nxt;

    // Issue pointer and read-pipeline tags (issue stage = addrb, then RAM stage)
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] issue_ptr, start_ptr, next_ptr;
    logic                     issue, issue_last, start_ok;
    logic                     s1_valid, s1_last, s2_valid, s2_last;
    logic [ADDRESS_WIDTH-1:0] s1_idx, s2_idx;

    // Three-entry output FIFO
    logic [DATA_WIDTH-1:0]    fifo_data [3];
    logic [ADDRESS_WIDTH-1:0] fifo_idx  [3];
    logic                     fifo_last [3];
    logic [1:0]               rd_ptr, wr_ptr, count;
    logic [2:0]               level;
    logic                     push, pop, room;

    assign start_ok = (state == IDLE) && start;

`ifdef KEY_FETCH_REVERSE_EN
    logic rev_q;
    logic rev_eff;

    // Direction is captured once per pass and held until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rev_q <= 1'b0;
        else if (start_ok) rev_q <= reverse;
    end

    assign rev_eff    = start_ok ? reverse : rev_q;
    assign start_ptr  = reverse ? LAST_IDX : '0;
    assign issue_last = rev_eff ? (issue_ptr == '0) : (issue_ptr == LAST_IDX);
    assign next_ptr   = rev_eff ? (issue_ptr - ONE) : (issue_ptr + ONE);
`else
    logic unused_reverse;
    assign unused_reverse = reverse;
    assign start_ptr      = '0;
    assign issue_last     = (issue_ptr == LAST_IDX);
    assign next_ptr       = issue_ptr + ONE;
`endif

    // The first read goes out on the start cycle itself, so IDLE uses the
    // start pointer directly instead of waiting for ptr to be loaded.
    assign issue_ptr = (state == IDLE) ? start_ptr : ptr;

    assign key_valid = (count != 2'd0);
    assign pop       = key_valid && key_ready;
    assign push      = s2_valid;
    assign key_out   = fifo_data[rd_ptr];
    assign key_idx   = fifo_idx[rd_ptr];
    assign key_last  = fifo_last[rd_ptr];
    assign busy      = (state != IDLE);

    // Buffered keys plus reads still in flight may never exceed FIFO depth
    assign level = {1'b0, count} + {2'b00, s1_valid} + {2'b00, s2_valid};
    assign room  = 3'(level - {2'b00, pop}) < 3'd3;
    assign issue = start_ok || ((state == FETCH) && room);

    // State and done-pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state: issue reads until the last one, then drain the FIFO
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (issue && issue_last) state_nxt = DRAIN;
            DRAIN:   if (pop && key_last) begin
                         state_nxt = IDLE;
                         done_nxt  = 1'b1;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: RAM address, pointer step and the tag that follows the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            addrb    <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                ptr     <= next_ptr;
                addrb   <= BASE + issue_ptr;
                s1_idx  <= issue_ptr;
                s1_last <= issue_last;
            end
        end
    end

    // RAM stage: tag lines up with doutb, which arrives one cycle after addrb
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_last  <= s1_last;
        end
    end

    // Output FIFO: capture returning RAM data, release on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= doutb;
                fifo_idx[wr_ptr]  <= s2_idx;
                fifo_last[wr_ptr] <= s2_last;
                wr_ptr            <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule
`default_nettype wire
